// File: rtl/fifo_wconv.sv
// Width-converting synchronous FIFO: packs/unpacks beats into W = max(IN_W, OUT_W) words,
// first-word-fall-through output, full DEPTH capacity, fill level and almost flags.
module fifo_wconv #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned ASIZE    = 10,
  parameter int unsigned AF_LEVEL = (1 << ASIZE) - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [31:0]      count,
  output logic [ASIZE:0]   words,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int unsigned W         = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam int unsigned DEPTH     = 1 << ASIZE;
  localparam int unsigned IN_LANES  = W / IN_W;
  localparam int unsigned OUT_LANES = W / OUT_W;
  localparam int unsigned IN_LW     = (IN_LANES > 1) ? $clog2(IN_LANES) : 1;
  localparam int unsigned OUT_LW    = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;

  logic [W-1:0]      mem [DEPTH];
  logic [W-1:0]      dout_q;
  logic [ASIZE:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, words_q, words_d;
  logic [IN_LW-1:0]  wr_lane_q, wr_lane_d;
  logic [OUT_LW-1:0] rd_lane_q, rd_lane_d;
  logic [W-1:0]      asm_q, asm_d, wword;
  logic              out_vld_q, out_vld_d;
  logic [31:0]       count_q, count_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic              clear, in_fire, out_fire, in_lane_last, out_lane_last, commit, free, load;

  assign clear         = rst | flush;
  assign in_ready      = (words_q < (ASIZE + 1)'(DEPTH));
  assign in_fire       = in_valid & in_ready;
  assign out_fire      = out_vld_q & out_ready;
  assign in_lane_last  = (wr_lane_q == IN_LW'(IN_LANES - 1));
  assign out_lane_last = (rd_lane_q == OUT_LW'(OUT_LANES - 1));
  // in_last only matters when a word spans several input beats
  assign commit        = in_fire & (in_lane_last | ((IN_LANES > 1) & in_last));
  assign free          = out_fire & out_lane_last;
  // Lanes above the current one are still zero, so OR-ing in the beat is enough
  assign wword         = asm_q | (W'(in_data) << (IN_W * wr_lane_q));

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_lane_d = wr_lane_q;
    rd_lane_d = rd_lane_q;
    asm_d     = asm_q;
    if (in_fire) begin
      if (commit) begin
        asm_d     = '0;
        wr_lane_d = '0;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end else begin
        asm_d     = wword;
        wr_lane_d = wr_lane_q + 1'b1;
      end
    end
    if (out_fire) begin
      rd_lane_d = out_lane_last ? '0 : rd_lane_q + 1'b1;
      if (free) rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // The prefetch register mirrors mem[rd_ptr]; refill it when empty or just freed
    load      = (!out_vld_q || free) && (wr_ptr_q != rd_ptr_d);
    out_vld_d = (out_vld_q && !free) || load;
    words_d   = wr_ptr_d - rd_ptr_d;
    count_d   = 32'(words_d) * 32'(W) - 32'(rd_lane_d) * 32'(OUT_W);
    af_d      = (32'(words_d) >= AF_LEVEL);
    ae_d      = (32'(words_d) <= AE_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_lane_q <= '0;
      rd_lane_q <= '0;
      asm_q     <= '0;
      out_vld_q <= 1'b0;
      words_q   <= '0;
      count_q   <= '0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_lane_q <= wr_lane_d;
      rd_lane_q <= rd_lane_d;
      asm_q     <= asm_d;
      out_vld_q <= out_vld_d;
      words_q   <= words_d;
      count_q   <= count_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && !clear) mem[wr_ptr_q[ASIZE-1:0]] <= wword;
  end

  always_ff @(posedge clk) begin
    if (clear)     dout_q <= '0;
    else if (load) dout_q <= mem[rd_ptr_d[ASIZE-1:0]];
  end

  assign out_valid    = out_vld_q;
  assign out_data     = OUT_W'(dout_q >> (OUT_W * rd_lane_q));
  assign count        = count_q;
  assign words        = words_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule
